// File: rtl/hdmi_i2c_cfg_seq.sv
// hdmi_i2c_cfg_seq: walks a register table over I2C after power-up, then serves host writes.
module hdmi_i2c_cfg_seq #(
   parameter int QDIV = 270,
   parameter int PWR_WAIT = 12201000,
   parameter int NREG = 17,
   parameter logic [7:0] DEV_ADDR = 8'h72,
   parameter int RETRY_MAX = 3,
   parameter int GAP_Q = 8
)(
   input  logic       CLK108,
   input  logic       RST,
   input  logic       START,
   output logic [7:0] TBL_IDX,
   input  logic [7:0] TBL_REG,
   input  logic [7:0] TBL_DAT,
   input  logic       HOST_REQ,
   input  logic [7:0] HOST_REG,
   input  logic [7:0] HOST_DAT,
   output logic       HOST_DONE,
   output logic       HOST_ERR,
   output logic       SCL,
   output logic       SDA_OUT,
   input  logic       SDA_IN,
   output logic       BUSY,
   output logic       INIT_DONE,
   output logic       INIT_ERR
);
   typedef enum logic [2:0] {PWR, LOAD, START_C, BYTE, STOP_C, GAP, NEXT, IDLE} st_t;
   st_t st;
   logic [31:0] pcnt;
   logic [15:0] qcnt;
   logic [1:0] q, nb;
   logic [3:0] b;
   logic [7:0] g, retry;
   logic [23:0] sr;
   logic host, nak, start_pend, tick;
   assign tick = qcnt == 16'(QDIV - 1);
   assign BUSY = st != IDLE;
   always_ff @(posedge CLK108) begin
      if (RST) begin
         st <= PWR;
         SCL <= 1'b1;
         SDA_OUT <= 1'b1;
         INIT_DONE <= 1'b0;
         INIT_ERR <= 1'b0;
         TBL_IDX <= '0;
         HOST_DONE <= 1'b0;
         HOST_ERR <= 1'b0;
         pcnt <= '0;
         qcnt <= '0;
         q <= '0;
         nb <= '0;
         b <= '0;
         g <= '0;
         retry <= '0;
         sr <= '0;
         host <= 1'b0;
         nak <= 1'b0;
         start_pend <= 1'b0;
      end else begin
         HOST_DONE <= 1'b0;
         HOST_ERR <= 1'b0;
         qcnt <= tick ? 16'd0 : qcnt + 16'd1;
         if (START) start_pend <= 1'b1;
         case (st)
            PWR: begin
               pcnt <= pcnt + 32'd1;
               if (pcnt == 32'(PWR_WAIT - 1)) st <= LOAD;
            end
            LOAD: begin
               sr <= host ? {DEV_ADDR, HOST_REG, HOST_DAT} : {DEV_ADDR, TBL_REG, TBL_DAT};
               qcnt <= '0;
               q <= '0;
               b <= '0;
               nb <= '0;
               nak <= 1'b0;
               st <= START_C;
            end
            START_C: if (tick) begin
               q <= q + 2'd1;
               if (q == 2'd0) SDA_OUT <= 1'b0;
               else begin
                  SCL <= 1'b0;
                  q <= '0;
                  st <= BYTE;
               end
            end
            BYTE: if (tick) begin
               q <= q + 2'd1;
               case (q)
                  2'd0: SDA_OUT <= (b == 4'd8) | sr[23];
                  2'd1: SCL <= 1'b1;
                  2'd2: if (b == 4'd8) nak <= SDA_IN;
                  2'd3: begin
                     SCL <= 1'b0;
                     if (b == 4'd8) begin
                        b <= '0;
                        nb <= nb + 2'd1;
                        if (nak || nb == 2'd2) st <= STOP_C;
                     end else begin
                        b <= b + 4'd1;
                        sr <= sr << 1;
                     end
                  end
               endcase
            end
            STOP_C: if (tick) begin
               q <= q + 2'd1;
               case (q)
                  2'd0: SDA_OUT <= 1'b0;
                  2'd1: SCL <= 1'b1;
                  2'd2: SDA_OUT <= 1'b1;
                  2'd3: begin
                     g <= '0;
                     st <= GAP;
                  end
               endcase
            end
            GAP: if (tick) begin
               g <= g + 8'd1;
               if (g == 8'(GAP_Q - 1)) begin
                  st <= NEXT;
                  // host completion is final once no retry will follow
                  if (host && (!nak || retry == 8'(RETRY_MAX))) begin
                     HOST_DONE <= 1'b1;
                     HOST_ERR <= nak;
                  end
               end
            end
            NEXT: begin
               if (nak && retry < 8'(RETRY_MAX)) begin
                  retry <= retry + 8'd1;
                  st <= LOAD;
               end else begin
                  retry <= '0;
                  if (host) begin
                     host <= 1'b0;
                     st <= IDLE;
                  end else begin
                     if (nak) INIT_ERR <= 1'b1;
                     if (TBL_IDX == 8'(NREG - 1)) begin
                        INIT_DONE <= 1'b1;
                        TBL_IDX <= '0;
                        st <= IDLE;
                     end else begin
                        TBL_IDX <= TBL_IDX + 8'd1;
                        st <= LOAD;
                     end
                  end
               end
            end
            IDLE: begin
               if (start_pend || START) begin
                  start_pend <= 1'b0;
                  INIT_DONE <= 1'b0;
                  INIT_ERR <= 1'b0;
                  TBL_IDX <= '0;
                  st <= LOAD;
               end else if (HOST_REQ && INIT_DONE) begin
                  host <= 1'b1;
                  st <= LOAD;
               end
            end
         endcase
      end
   end
endmodule
